fsb8_target: RTL and testbench
==============================

# fsb8_target

FSB8 bus target interface for peripheral/memory chips hanging off the FSB8 bus that `fsb8` masters from the KC-LS1u SoC. It decodes the multiplexed address/data phases, qualifies the access against a base/mask window, and issues single-byte requests on a simple req/ack local port. It returns `rdy_n` and read data to the bus and forwards a device interrupt onto `irq_n`. The block sits directly downstream of the SoC's FSB8 pins, on the board or in a companion FPGA, clocked by `busclk`/`busrst_n`.

## Interface
- PAE_ENABLE, 1, 1: address byte A[31:24] from phase 2 is decoded; 0: A[31:24] is forced to 0.
- BASE_ADDR, 32'h0000_0000: window base.
- BASE_MASK, 32'hFFF0_0000: hit when `(A & BASE_MASK) == (BASE_ADDR & BASE_MASK)`.
- clk  in  1  FSB8 bus clock (`busclk`).
- rst_n  in  1  asynchronous, active-low reset (`busrst_n`).
- ale_n, cs_n, cmd_n, typ, wr_n  in  1 each  FSB8 control; `typ`=1 means 4-beat block.
- AD_in  in  8  AD8 input.
- AAH8  in  8  high address byte.
- AD_out  out  8  AD8 output data.
- ADdir  out  1  1 means the target drives AD8.
- rdy_n  out  1  beat-complete strobe, active low.
- irq_n  out  1  interrupt, active low.
- m_addr  out  32  local byte address.
- m_wdata  out  8  local write data.
- m_we  out  1  local write enable, qualified by m_req.
- m_req  out  1  local request.
- m_ack  in  1  local completion. Read data is valid in the same cycle.
- m_rdata  in  8  local read data.
- dev_irq  in  1  device interrupt, active high.

## Operation
- All outputs are registered. Reset values: AD_out=0, ADdir=0, rdy_n=1, irq_n=1, m_addr=0, m_wdata=0, m_we=0, m_req=0. The FSM resets to IDLE.
- States: IDLE, ADDR2, DATA, REQ, RDY, WAITEND, ABORT.
- IDLE: when `ale_n=0 & cs_n=0 & cmd_n=1` is sampled, the block latches A[7:0]=AD_in, A[15:8]=AAH8, wr_n and typ, then goes to ADDR2. Command cycles (`cmd_n=0`) are ignored.
- ADDR2: when `ale_n=0` is sampled, the block latches A[23:16]=AD_in and A[31:24]=AAH8 (or 0 if !PAE_ENABLE), then decodes the address. A hit goes to DATA with beat count 0. A miss, or `ale_n=1` in ADDR2, goes to WAITEND.
- DATA: for a write, AD_in is sampled into m_wdata. The block then goes to REQ. m_addr = {A[31:2], A[1:0]+beat} (beat counter wraps within the 4-byte block).
- REQ: m_req=1 and m_we=~wr_n are held until m_ack is sampled high. On ack the block goes to RDY, and for a read it latches m_rdata into AD_out.
- RDY: rdy_n=0 for exactly one cycle. For a read, ADdir=1 in that cycle only. m_req=0. If typ=1 and beat<3, beat increments and the block goes to DATA. Otherwise it goes to WAITEND.
- WAITEND: ADdir=0. Returns to IDLE when cs_n=1 is sampled.
- Abort: cs_n=1 sampled in ADDR2, DATA or RDY returns to IDLE next cycle. cs_n=1 sampled in REQ goes to ABORT. ABORT keeps m_req asserted until m_ack, discards the data, never pulses rdy_n, then goes to IDLE. The local handshake is never dropped mid-request.
- irq_n is `~dev_irq` registered through a two-flop synchronizer.
- Reset asserted mid-transfer returns all outputs to their reset values immediately and asynchronously, including m_req.

## Timing
- Write data on AD8 must be valid at the edge that ends the cycle after ALE phase 2 (the first beat). For later beats it must be valid at the edge that ends the cycle after the rdy_n pulse.
- Zero-wait single access: phase 1 in cycle 0, phase 2 in cycle 1, DATA in cycle 2, m_req high in cycle 3. With m_ack in cycle 3, rdy_n is low in cycle 4.
- Each local wait cycle adds one cycle of REQ. A 4-beat zero-wait block takes 4 + 3×3 = 13 cycles from phase 1 to the last rdy_n.
- m_req deasserts in the cycle after m_ack is sampled. m_ack asserted outside REQ or ABORT is ignored.
- Read data on AD_out is valid only while rdy_n=0.

## Test plan
- Single write hit: address 0x00012345, data 0xA5, m_ack zero-wait. Expect m_req high in cycle 3 with m_addr=0x00012345, m_we=1, m_wdata=0xA5, then rdy_n low for one cycle in cycle 4.
- Block read: typ=1, address 0x00000102, m_rdata=0x10/0x11/0x12/0x13. Expect m_addr 0x102, 0x103, 0x100, 0x101 (wrap), four rdy_n pulses, and AD_out matching each pulse with ADdir=1 only during the pulses.
- Miss: address 0x40000000 with default base/mask. Expect no m_req, rdy_n stays 1, ADdir stays 0, and the FSM is back in IDLE after cs_n rises.
- Local wait states: read with m_ack delayed 5 cycles. Expect m_req held for 6 cycles and rdy_n low exactly once, one cycle after ack.
- Abort: cs_n raised while in REQ, m_ack arrives 3 cycles later. Expect m_req held until the ack, no rdy_n pulse, return to IDLE, and a following access that completes normally.
- Reset and interrupt: rst_n pulsed low during REQ gives all reset values immediately. dev_irq=1 gives irq_n=0 two clocks later.

Source files
------------

// File: rtl/fsb8_target_if.sv
// FSB8 target-side signal bundle: bus pins plus the local req/ack port.
// The slave modport is the target's view; master is the bus/memory side.
interface fsb8_target_if;
   logic        ale_n, cs_n, cmd_n, typ, wr_n;
   logic [7:0]  AD_in, AAH8, AD_out;
   logic        ADdir, rdy_n, irq_n;
   logic [31:0] m_addr;
   logic [7:0]  m_wdata, m_rdata;
   logic        m_we, m_req, m_ack, dev_irq;

   modport slave (
      input  ale_n, cs_n, cmd_n, typ, wr_n, AD_in, AAH8, m_ack, m_rdata, dev_irq,
      output AD_out, ADdir, rdy_n, irq_n, m_addr, m_wdata, m_we, m_req
   );

   modport master (
      output ale_n, cs_n, cmd_n, typ, wr_n, AD_in, AAH8, m_ack, m_rdata, dev_irq,
      input  AD_out, ADdir, rdy_n, irq_n, m_addr, m_wdata, m_we, m_req
   );
endinterface

// File: rtl/fsb8_target.sv
// FSB8 bus target: decodes the two address phases, matches a base/mask window
// and turns each beat into a single-byte req/ack request on the local port.
module fsb8_target #(
   parameter bit          PAE_ENABLE = 1'b1,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter logic [31:0] BASE_MASK  = 32'hFFF0_0000
) (
   input logic          clk,
   input logic          rst_n,
   fsb8_target_if.slave bus
);

   typedef enum logic [2:0] {IDLE, ADDR2, DATA, REQ, RDY, WAITEND, ABORT} state_t;

   state_t      state;
   logic [31:0] addr;
   logic        wr_q, typ_q, irq_s;
   logic [1:0]  beat;
   logic [31:0] a_full;
   logic        hit;

   // Full address as it will look once phase 2 is latched; decoded in ADDR2.
   assign a_full = {(PAE_ENABLE ? bus.AAH8 : 8'h00), bus.AD_in, addr[15:0]};
   assign hit    = ((a_full & BASE_MASK) == (BASE_ADDR & BASE_MASK));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         addr        <= '0;
         wr_q        <= 1'b1;
         typ_q       <= 1'b0;
         beat        <= '0;
         irq_s       <= 1'b1;
         bus.irq_n   <= 1'b1;
         bus.AD_out  <= '0;
         bus.ADdir   <= 1'b0;
         bus.rdy_n   <= 1'b1;
         bus.m_addr  <= '0;
         bus.m_wdata <= '0;
         bus.m_we    <= 1'b0;
         bus.m_req   <= 1'b0;
      end else begin
         irq_s     <= ~bus.dev_irq;
         bus.irq_n <= irq_s;
         case (state)
            IDLE: begin
               if (!bus.ale_n && !bus.cs_n && bus.cmd_n) begin
                  addr[15:0] <= {bus.AAH8, bus.AD_in};
                  wr_q       <= bus.wr_n;
                  typ_q      <= bus.typ;
                  state      <= ADDR2;
               end
            end
            ADDR2: begin
               if (bus.cs_n) state <= IDLE;
               else if (!bus.ale_n) begin
                  addr[31:16] <= a_full[31:16];
                  beat        <= '0;
                  state       <= hit ? DATA : WAITEND;
               end else state <= WAITEND;
            end
            DATA: begin
               if (bus.cs_n) state <= IDLE;
               else begin
                  if (!wr_q) bus.m_wdata <= bus.AD_in;
                  bus.m_addr <= {addr[31:2], addr[1:0] + beat};
                  bus.m_req  <= 1'b1;
                  bus.m_we   <= ~wr_q;
                  state      <= REQ;
               end
            end
            REQ: begin
               // An ack that coincides with cs_n rising completes the handshake;
               // the data is simply dropped.
               if (bus.m_ack) begin
                  bus.m_req <= 1'b0;
                  bus.m_we  <= 1'b0;
                  if (bus.cs_n) state <= IDLE;
                  else begin
                     if (wr_q) bus.AD_out <= bus.m_rdata;
                     bus.rdy_n <= 1'b0;
                     bus.ADdir <= wr_q;
                     state     <= RDY;
                  end
               end else if (bus.cs_n) state <= ABORT;
            end
            RDY: begin
               bus.rdy_n <= 1'b1;
               bus.ADdir <= 1'b0;
               if (bus.cs_n) state <= IDLE;
               else if (typ_q && beat != 2'd3) begin
                  beat  <= beat + 2'd1;
                  state <= DATA;
               end else state <= WAITEND;
            end
            WAITEND: begin
               bus.ADdir <= 1'b0;
               if (bus.cs_n) state <= IDLE;
            end
            ABORT: begin
               if (bus.m_ack) begin
                  bus.m_req <= 1'b0;
                  bus.m_we  <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fsb8_target.sv
// Directed plus random bench for fsb8_target; expectations come from a
// cycle-timing model of the bus protocol and a base/mask address model.
module tb_fsb8_target;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fsb8_target_if bus();
   fsb8_target dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int checks = 0;
   int errors = 0;
   logic [7:0] t_wd[4];
   logic [7:0] t_rd[4];
   int         t_wt[4];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.ale_n = 1; bus.cs_n = 1; bus.cmd_n = 1; bus.typ = 0; bus.wr_n = 1;
      bus.AD_in = 0; bus.AAH8 = 0; bus.m_ack = 0; bus.m_rdata = 0;
   endtask

   task automatic drive_phase(input int c, input logic [31:0] a, input bit wr, input bit blk);
      bus.ale_n = !(c < 2); bus.cs_n = 0; bus.cmd_n = 1;
      bus.wr_n = !wr; bus.typ = blk;
      if (c == 0) begin bus.AD_in = a[7:0]; bus.AAH8 = a[15:8]; end
      else if (c == 1) begin bus.AD_in = a[23:16]; bus.AAH8 = a[31:24]; end
      else begin bus.AD_in = 8'($urandom); bus.AAH8 = 8'($urandom); end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_AD_out"}, bus.AD_out, 0);
      chk({tag, "_ADdir"}, bus.ADdir, 0);
      chk({tag, "_rdy_n"}, bus.rdy_n, 1);
      chk({tag, "_irq_n"}, bus.irq_n, 1);
      chk({tag, "_m_addr"}, bus.m_addr, 0);
      chk({tag, "_m_wdata"}, bus.m_wdata, 0);
      chk({tag, "_m_we"}, bus.m_we, 0);
      chk({tag, "_m_req"}, bus.m_req, 0);
   endtask

   // One complete bus access; beat j requests at reqc[j], completes after t_wt[j] waits.
   task automatic xfer(input logic [31:0] a, input bit wr, input bit blk);
      bit hit, rq, rl;
      int nb, last, jq, jr;
      int reqc[4];
      hit = ((a & 32'hFFF0_0000) == 32'h0);
      nb = blk ? 4 : 1;
      reqc[0] = 3;
      for (int j = 1; j < 4; j++) reqc[j] = reqc[j-1] + t_wt[j-1] + 3;
      last = hit ? reqc[nb-1] + t_wt[nb-1] + 2 : 8;
      for (int c = 0; c <= last; c++) begin
         @(negedge clk);
         rq = 0; rl = 0; jq = 0; jr = 0;
         if (hit) for (int j = 0; j < nb; j++) begin
            if (c >= reqc[j] && c <= reqc[j] + t_wt[j]) begin rq = 1; jq = j; end
            if (c == reqc[j] + t_wt[j] + 1) begin rl = 1; jr = j; end
         end
         chk("m_req", bus.m_req, rq);
         chk("rdy_n", bus.rdy_n, !rl);
         chk("ADdir", bus.ADdir, rl && !wr);
         if (rq) begin
            chk("m_addr", bus.m_addr, (a & ~32'h3) | ((a + jq) & 32'h3));
            chk("m_we", bus.m_we, wr);
            if (wr) chk("m_wdata", bus.m_wdata, t_wd[jq]);
         end
         if (rl && !wr) chk("AD_out", bus.AD_out, t_rd[jr]);
         drive_phase(c, a, wr, blk);
         bus.m_ack = 0; bus.m_rdata = 8'($urandom);
         if (!rq) bus.m_ack = 1'($urandom_range(0, 1));
         if (hit) for (int j = 0; j < nb; j++) begin
            if (c == reqc[j] - 1) bus.AD_in = t_wd[j];
            if (c == reqc[j] + t_wt[j]) begin bus.m_ack = 1; bus.m_rdata = t_rd[j]; end
         end
      end
      @(negedge clk);
      chk("end_m_req", bus.m_req, 0);
      chk("end_ADdir", bus.ADdir, 0);
      idle_inputs();
      @(negedge clk);
      chk("idle_rdy_n", bus.rdy_n, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      idle_inputs();
      bus.dev_irq = 0;
      for (int i = 0; i < 4; i++) begin t_wd[i] = 0; t_rd[i] = 0; t_wt[i] = 0; end
      repeat (2) @(negedge clk);
      chk_reset_vals("rst");
      rst_n = 1;
      repeat (2) @(negedge clk);

      // single zero-wait write hit
      t_wd[0] = 8'hA5;
      xfer(32'h0001_2345, 1, 0);
      // 4-beat read with address wrap
      for (int i = 0; i < 4; i++) t_rd[i] = 8'h10 + 8'(i);
      xfer(32'h0000_0102, 0, 1);
      // miss outside the window
      xfer(32'h4000_0000, 0, 0);
      // read with five local wait states
      t_wt[0] = 5; t_rd[0] = 8'h5C;
      xfer(32'h0000_0800, 0, 0);
      t_wt[0] = 0;

      // abort in REQ, ack three cycles later
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk("abort_m_req", bus.m_req, (c >= 3 && c <= 6));
         chk("abort_rdy_n", bus.rdy_n, 1);
         chk("abort_ADdir", bus.ADdir, 0);
         drive_phase(c, 32'h0000_0040, 0, 0);
         bus.cs_n = (c >= 3);
         bus.m_ack = (c == 6);
      end
      idle_inputs();
      t_rd[0] = 8'h77;
      xfer(32'h0000_0041, 0, 0);

      // interrupt synchronizer latency
      @(negedge clk); bus.dev_irq = 1;
      @(negedge clk); chk("irq_1clk", bus.irq_n, 1);
      @(negedge clk); chk("irq_2clk", bus.irq_n, 0);

      // async reset during REQ
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (c == 3) chk("pre_rst_m_req", bus.m_req, 1);
         else drive_phase(c, 32'h0000_0033, 0, 0);
      end
      #1 rst_n = 0;
      #1 chk_reset_vals("async_rst");
      idle_inputs();
      @(negedge clk); rst_n = 1;
      @(negedge clk); chk("irq_after_rst1", bus.irq_n, 1);
      @(negedge clk); chk("irq_after_rst2", bus.irq_n, 0);
      bus.dev_irq = 0;
      @(negedge clk); chk("irq_clear1", bus.irq_n, 0);
      @(negedge clk); chk("irq_clear2", bus.irq_n, 1);

      // random accesses
      for (int n = 0; n < 40; n++) begin
         logic [31:0] a;
         a = $urandom & 32'h000F_FFFF;
         if ($urandom_range(0, 3) == 0) a = a | (32'($urandom_range(1, 4095)) << 20);
         for (int i = 0; i < 4; i++) begin
            t_wd[i] = 8'($urandom); t_rd[i] = 8'($urandom); t_wt[i] = $urandom_range(0, 3);
         end
         xfer(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
